// File: rtl/glitch_pkg.sv
// Constants and state encoding shared by the glitch generator, the glitch monitor
// and their benches, so every side agrees on default counts.
package glitch_pkg;

    localparam int unsigned DEFAULT_CNT_WIDTH     = 32;
    localparam int unsigned DEFAULT_SYNC_STAGES   = 2;
    localparam int unsigned DEFAULT_DELAY_COUNT   = 100;
    localparam int unsigned DEFAULT_GWIDTH_COUNT  = 20;
    localparam logic [31:0] DEFAULT_TIMEOUT_COUNT = 32'd400_000_000;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DELAY   = 3'd1,
        ST_WIDTH   = 3'd2,
        ST_REPORT  = 3'd3,
        ST_RELEASE = 3'd4
    } mon_state_e;

endpackage : glitch_pkg

// File: rtl/glitch_monitor_if.sv
// Result channel from the glitch monitor to a readout/logging block (valid/ready).
interface glitch_monitor_if #(
    parameter int unsigned CNT_WIDTH = glitch_pkg::DEFAULT_CNT_WIDTH
);

    logic [CNT_WIDTH-1:0] meas_delay;
    logic [CNT_WIDTH-1:0] meas_width;
    logic                 meas_timeout;
    logic                 meas_valid;
    logic                 meas_ready;

    modport master (
        output meas_delay,
        output meas_width,
        output meas_timeout,
        output meas_valid,
        input  meas_ready
    );

    modport slave (
        input  meas_delay,
        input  meas_width,
        input  meas_timeout,
        input  meas_valid,
        output meas_ready
    );

endinterface : glitch_monitor_if

// File: rtl/glitch_monitor_sync_rise.sv
// Multi-flop synchronizer for one asynchronous input, plus a rising-edge strobe
// built only from registered signals.
module sync_rise #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic level_o,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbour; blocking here would collapse the chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule : sync_rise

// File: rtl/glitch_monitor.sv
// Measures trigger-rise to glitch-rise delay and glitch high time in clk cycles
// and hands each result to a consumer over a valid/ready channel.
module glitch_monitor
    import glitch_pkg::*;
#(
    parameter int unsigned          CNT_WIDTH     = DEFAULT_CNT_WIDTH,
    parameter logic [CNT_WIDTH-1:0] TIMEOUT_COUNT = DEFAULT_TIMEOUT_COUNT,
    parameter int unsigned          SYNC_STAGES   = DEFAULT_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trigger,
    input  logic             glitch,
    glitch_monitor_if.master meas_if,
    output logic             busy
);

    logic trig_s;
    logic trig_rise;
    logic glit_s;
    logic glit_rise_unused;

    // Both inputs see identical synchronizer latency, so it cancels out of the delay.
    sync_rise #(.SYNC_STAGES(SYNC_STAGES)) u_sync_trig (
        .clk     (clk),
        .rst     (rst),
        .d_i     (trigger),
        .level_o (trig_s),
        .rise_o  (trig_rise)
    );

    sync_rise #(.SYNC_STAGES(SYNC_STAGES)) u_sync_glit (
        .clk     (clk),
        .rst     (rst),
        .d_i     (glitch),
        .level_o (glit_s),
        .rise_o  (glit_rise_unused)
    );

    mon_state_e           state_q, state_d;
    logic [CNT_WIDTH-1:0] dcnt_q, dcnt_d;
    logic [CNT_WIDTH-1:0] wcnt_q, wcnt_d;
    logic [CNT_WIDTH-1:0] delay_q, delay_d;
    logic [CNT_WIDTH-1:0] width_q, width_d;
    logic                 timeout_q, timeout_d;
    logic                 valid_q, valid_d;
    logic                 busy_q;

    // NOTE: every register is cleared by reset, including the result registers,
    // so a reset mid-measurement leaves nothing stale on the result channel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            dcnt_q    <= '0;
            wcnt_q    <= '0;
            delay_q   <= '0;
            width_q   <= '0;
            timeout_q <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dcnt_q    <= dcnt_d;
            wcnt_q    <= wcnt_d;
            delay_q   <= delay_d;
            width_q   <= width_d;
            timeout_q <= timeout_d;
            valid_q   <= valid_d;
            busy_q    <= (state_d != ST_IDLE);
        end
    end

    // NOTE: all outputs of this block get a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        dcnt_d    = dcnt_q;
        wcnt_d    = wcnt_q;
        delay_d   = delay_q;
        width_d   = width_q;
        timeout_d = timeout_q;
        valid_d   = valid_q;

        unique case (state_q)
            ST_IDLE: begin
                if (trig_rise) begin
                    if (glit_s) begin
                        dcnt_d  = '0;
                        wcnt_d  = CNT_WIDTH'(1);
                        state_d = ST_WIDTH;
                    end else begin
                        dcnt_d  = CNT_WIDTH'(1);
                        state_d = ST_DELAY;
                    end
                end
            end

            ST_DELAY: begin
                if (glit_s) begin
                    wcnt_d  = CNT_WIDTH'(1);
                    state_d = ST_WIDTH;
                end else if (dcnt_q == TIMEOUT_COUNT) begin
                    delay_d   = dcnt_q;
                    width_d   = '0;
                    timeout_d = 1'b1;
                    valid_d   = 1'b1;
                    state_d   = ST_REPORT;
                end else begin
                    dcnt_d = dcnt_q + CNT_WIDTH'(1);
                end
            end

            ST_WIDTH: begin
                if (glit_s) begin
                    if (wcnt_q != '1) begin
                        wcnt_d = wcnt_q + CNT_WIDTH'(1);
                    end
                end else begin
                    delay_d   = dcnt_q;
                    width_d   = wcnt_q;
                    timeout_d = 1'b0;
                    valid_d   = 1'b1;
                    state_d   = ST_REPORT;
                end
            end

            ST_REPORT: begin
                if (valid_q && meas_if.meas_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_RELEASE;
                end
            end

            ST_RELEASE: begin
                // A trigger still high from the last shot must drop before re-arming.
                if (!trig_s) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign meas_if.meas_delay   = delay_q;
    assign meas_if.meas_width   = width_q;
    assign meas_if.meas_timeout = timeout_q;
    assign meas_if.meas_valid   = valid_q;
    assign busy                 = busy_q;

endmodule : glitch_monitor
